// File: rtl/alu_shift_pkg.sv
// Shared opcodes, FSM state encoding and command record for the shift issuer
// and the external shift unit.
package alu_shift_pkg;

    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SAR  = 4'b0111;
    localparam logic [3:0] OP_ROTL = 4'b1000;
    localparam logic [3:0] OP_ROTR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SAR) || (op == OP_ROTL) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; push is ignored when full and pop
// when empty, and a simultaneous push/pop leaves the occupancy unchanged.
module alu_cmd_fifo
    import alu_shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_shift_issuer.sv
// Queues shift commands, presents each to the external combinational shift unit
// for SETTLE cycles, and returns the captured result with a completion count.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting; pops the FIFO head into the command register
//   ST_ISSUE | operands driven to the shift unit for SETTLE cycles
//   ST_RESP  | response held on rsp_* until rsp_ready
module alu_shift_issuer
    import alu_shift_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [15:0] rsp_count,
    output logic        busy
);

    localparam int CW = $clog2(SETTLE + 1);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [15:0]     result_q, result_d;
    logic            err_q, err_d;
    logic [15:0]     count_q, count_d;
    logic            ready_q;

    cmd_t            fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            drive_alu;

    // ready_q keeps cmd_ready low through reset and raises it one edge later.
    assign cmd_ready  = ready_q && !fifo_full;
    assign drive_alu  = (state_q == ST_ISSUE) && is_legal_op(cmd_q.op);
    assign alu_opcode = drive_alu ? cmd_q.op : '0;
    assign alu_a      = drive_alu ? cmd_q.a  : '0;
    assign alu_b      = drive_alu ? cmd_q.b  : '0;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign rsp_count  = count_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i ('{op: cmd_op, a: cmd_a, b: cmd_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        settle_d = settle_q;
        result_d = result_q;
        err_d    = err_q;
        count_d  = count_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    settle_d = CW'(SETTLE - 1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (settle_q == '0) begin
                    result_d = is_legal_op(cmd_q.op) ? alu_result : 16'h0000;
                    err_d    = !is_legal_op(cmd_q.op);
                    state_d  = ST_RESP;
                end else begin
                    settle_d = settle_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            settle_q <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            settle_q <= settle_d;
            result_q <= result_d;
            err_q    <= err_d;
            count_q  <= count_d;
            ready_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_shift_issuer.sv
// Bench for alu_shift_issuer: behavioural shift unit, queue-based response
// model, directed latency/backpressure/reset cases and a randomized run.
module tb_alu_shift_issuer;
    import alu_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic [15:0] rsp_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt = 0;

    always #5 clk = ~clk;

    alu_shift_issuer #(.DEPTH(4), .SETTLE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_count  (rsp_count),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift unit behaviour in plain arithmetic; rotations use the amount mod 16.
    function automatic logic [15:0] shift_ref(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int av, n, v, p, q;
        av = int'(a);
        n  = int'(b) % 16;
        case (op)
            OP_SLL: return (b >= 16) ? 16'h0000 : 16'(av * (1 << b));
            OP_SAR: begin
                if (b >= 16) return a[15] ? 16'hFFFF : 16'h0000;
                v = a[15] ? av - 65536 : av;
                p = 1 << b;
                q = (v >= 0) ? v / p : -((-v + p - 1) / p);
                return 16'(q);
            end
            OP_ROTL: return 16'((av << n) | (av >> (16 - n)));
            OP_ROTR: return 16'((av >> n) | (av << (16 - n)));
            default: return 16'hBAD0;
        endcase
    endfunction

    assign alu_result = shift_ref(alu_opcode, alu_a, alu_b);

    function automatic exp_t expect_of(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        if (op inside {OP_SLL, OP_SAR, OP_ROTL, OP_ROTR}) begin
            e.res = shift_ref(op, a, b);
            e.err = 1'b0;
        end else begin
            e.res = 16'h0000;
            e.err = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rsp_valid)
                check_eq("alu_zero_in_resp", {alu_opcode, alu_a, alu_b}, 64'h0);
            if (rsp_valid && rsp_ready) begin
                check_eq("rsp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rsp_result", rsp_result, e.res);
                    check_eq("rsp_err", rsp_err, e.err);
                end
                check_eq("rsp_count_at_hs", rsp_count, 64'(model_cnt));
                model_cnt = (model_cnt + 1) & 32'hFFFF;
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(expect_of(cmd_op, cmd_a, cmd_b));
        end
    end

    always @(posedge rst) begin
        exp_q.delete();
        model_cnt = 0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string tag);
        int i;
        cyc();
        rsp_ready = 1'b1;
        for (i = 0; i < 300 && (busy || rsp_valid || exp_q.size() != 0); i++) smp();
        if (i == 300) check_eq({tag, "_drain_timeout"}, {busy, 32'(exp_q.size())}, 64'h0);
    endtask

    task automatic run_single(input string tag, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] res, input logic err,
                              input logic [3:0] aop, input logic [15:0] aa, input logic [15:0] ab);
        logic [15:0] seen;
        wait_quiet(tag);
        cyc();
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; rsp_ready = 1'b1;
        smp();
        check_eq({tag, "_c0_ready"}, cmd_ready, 1'b1);
        cyc();
        cmd_valid = 1'b0;
        smp();
        check_eq({tag, "_c1_alu_zero"}, {alu_opcode, alu_a, alu_b}, 64'h0);
        check_eq({tag, "_c1_busy"}, busy, 1'b1);
        cyc();
        smp();
        check_eq({tag, "_c2_alu_opcode"}, alu_opcode, aop);
        check_eq({tag, "_c2_alu_a"}, alu_a, aa);
        check_eq({tag, "_c2_alu_b"}, alu_b, ab);
        check_eq({tag, "_c2_rsp_valid"}, rsp_valid, 1'b0);
        seen = alu_result;
        cyc();
        smp();
        check_eq({tag, "_c3_rsp_valid"}, rsp_valid, 1'b1);
        check_eq({tag, "_c3_rsp_result"}, rsp_result, res);
        check_eq({tag, "_c3_rsp_err"}, rsp_err, err);
        if (!err) check_eq({tag, "_c3_result_vs_alu"}, rsp_result, seen);
        cyc();
        smp();
        check_eq({tag, "_c4_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({tag, "_c4_rsp_count"}, rsp_count, 64'(model_cnt));
    endtask

    task automatic rand_cmd();
        logic [3:0] legal [4];
        legal[0] = OP_SLL; legal[1] = OP_SAR; legal[2] = OP_ROTL; legal[3] = OP_ROTR;
        cmd_op = ($urandom_range(0, 9) < 7) ? legal[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
        cmd_a  = 16'($urandom);
        cmd_b  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent;
        int   guard;
        int   cnt0;
        logic acc;

        repeat (3) @(posedge clk);
        smp();
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_result, rsp_count}, 64'h0);
        check_eq("rst_alu", {alu_opcode, alu_a, alu_b}, 64'h0);
        check_eq("rst_busy", busy, 1'b0);
        #2 rst = 1'b0;
        smp();
        check_eq("rst_release_ready", cmd_ready, 1'b1);

        run_single("sll", OP_SLL, 16'h0001, 16'h0004, 16'h0010, 1'b0, OP_SLL, 16'h0001, 16'h0004);
        run_single("rotr16", OP_ROTR, 16'h0001, 16'h0010, 16'h0001, 1'b0, OP_ROTR, 16'h0001, 16'h0010);
        run_single("illegal", 4'b0000, 16'h1234, 16'h5678, 16'h0000, 1'b1, 4'h0, 16'h0, 16'h0);
        run_single("rotl", OP_ROTL, 16'h8001, 16'h0004, 16'h0018, 1'b0, OP_ROTL, 16'h8001, 16'h0004);

        // response held under backpressure
        wait_quiet("stall");
        cyc();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_SAR; cmd_a = 16'hF000; cmd_b = 16'h0004;
        cyc();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) smp();
        check_eq("stall_rsp_valid_seen", rsp_valid, 1'b1);
        cnt0 = model_cnt;
        for (int k = 0; k < 10; k++) begin
            check_eq("stall_hold", {rsp_valid, rsp_err, rsp_result, rsp_count}, {1'b1, 1'b0, 16'hFF00, 16'(cnt0)});
            smp();
        end
        wait_quiet("stall_release");

        // FIFO fill with responses blocked
        wait_quiet("bp");
        cyc();
        rsp_ready = 1'b0;
        cnt0 = model_cnt;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            rand_cmd();
            smp();
            check_eq($sformatf("bp_ready_c%0d", i), cmd_ready, i < 5);
            cyc();
        end
        cmd_valid = 1'b0;
        check_eq("bp_queued", exp_q.size(), 5);
        wait_quiet("bp_release");
        check_eq("bp_count", rsp_count, 64'((cnt0 + 5) & 32'hFFFF));

        // reset while a command is in ISSUE and another is queued
        wait_quiet("rst_mid");
        cyc();
        cmd_valid = 1'b1; cmd_op = OP_SLL; cmd_a = 16'h0003; cmd_b = 16'h0002;
        cyc();
        cmd_op = OP_ROTL; cmd_a = 16'h0005; cmd_b = 16'h0001;
        cyc();
        cmd_valid = 1'b0;
        smp();
        check_eq("rst_mid_in_issue", alu_opcode, OP_SLL);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid_alu", {alu_opcode, alu_a, alu_b}, 64'h0);
        check_eq("rst_mid_rsp", {rsp_valid, rsp_err, rsp_result, rsp_count}, 64'h0);
        check_eq("rst_mid_ready_busy", {cmd_ready, busy}, 64'h0);
        smp();
        smp();
        #2 rst = 1'b0;
        smp();
        check_eq("rst_mid_release_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_eq("rst_mid_no_resp", {rsp_valid, busy}, 64'h0);
            smp();
        end
        run_single("sar_after_rst", OP_SAR, 16'h8000, 16'h0001, 16'hC000, 1'b0, OP_SAR, 16'h8000, 16'h0001);

        // randomized traffic with random backpressure
        wait_quiet("rand_start");
        sent = 0;
        guard = 0;
        acc = 1'b0;
        cyc();
        while (sent < 300 && guard < 20000) begin
            guard++;
            if (acc) sent++;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!cmd_valid || acc) begin
                cmd_valid = (sent < 300) && ($urandom_range(0, 2) != 0);
                if (cmd_valid) rand_cmd();
            end
            smp();
            acc = cmd_valid && cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        check_eq("rand_all_sent", sent, 300);
        wait_quiet("rand_drain");
        check_eq("rand_final_count", rsp_count, 64'(model_cnt));
        check_eq("rand_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
